cpu_ram_arb: RTL and testbench
==============================

CPU_RAM_ARB -- requirements
Module: cpu_ram_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, meaning the byte-address width presented to cpu_ram (SIZE+2 for SIZE=13).
REQ-002 SHALL have parameter TIMEOUT, default 64, meaning the cycles waited in WAIT before a forced completion (used only with CPU_ARB_TIMEOUT_EN).
REQ-003 SHALL have ports, one per line (name  direction  width  meaning):
  clk  in  1  single clock, rising edge
  resetn  in  1  asynchronous, active-low reset
  m0_valid  in  1  master 0 request, held until m0_ready
  m0_addr  in  ADDR_W  master 0 byte address
  m0_wdata  in  32  master 0 write data
  m0_wstrb  in  4  master 0 byte strobes; 0000 = read
  m0_rdata  out  32  read data to master 0
  m0_ready  out  1  master 0 completion pulse
  m1_valid/m1_addr/m1_wdata/m1_wstrb/m1_rdata/m1_ready  same as m0, for master 1
  s_valid  out  1  one-cycle request pulse to cpu_ram
  s_addr  out  ADDR_W  latched address to cpu_ram
  s_wdata  out  32  latched write data to cpu_ram
  s_wstrb  out  4  latched strobes to cpu_ram
  s_rdata  in  32  read data from cpu_ram
  s_ready  in  1  completion from cpu_ram
  tout_err  out  1  one-cycle pulse on forced timeout completion

Function
REQ-004 SHALL implement a 4-state FSM: IDLE, ISSUE, WAIT, DONE.
REQ-005 IDLE: if any mX_valid, SHALL select a grant, latch that master's addr/wdata/wstrb into s_addr/s_wdata/s_wstrb and go to ISSUE; else stay.
REQ-006 Grant SHALL be round-robin: one requester wins; if both request, the master not served last wins; last-served register resets to 1, so master 0 wins the first tie.
REQ-007 ISSUE: s_valid SHALL be 1 for exactly this one cycle; next state WAIT.
REQ-008 WAIT: on s_ready=1 SHALL capture s_rdata into the rdata register and go to DONE; s_ready outside WAIT SHALL be ignored.
REQ-009 DONE: m_ready of the granted master only SHALL be 1 for exactly one cycle; last-served SHALL update to the grant; next state IDLE.
REQ-010 m0_rdata and m1_rdata SHALL both drive the shared rdata register, stable from DONE until the next WAIT capture.
REQ-011 Latency SHALL be: request sampled in IDLE at edge N -> s_valid in cycle N+1 -> m_ready exactly 1 cycle after the cycle with s_ready high.
REQ-012 Masters deassert valid the cycle after ready; the IDLE cycle following DONE therefore SHALL NOT re-grant the completed request.
REQ-013 Changes on non-granted master inputs during ISSUE/WAIT/DONE SHALL not affect s_* outputs.
REQ-014 For writes (wstrb!=0), rdata SHALL still be captured from s_rdata and its value is don't-care.

Reset
REQ-015 resetn=0 SHALL asynchronously force: state IDLE, s_valid=0, m0_ready=0, m1_ready=0, tout_err=0, s_addr=0, s_wdata=0, s_wstrb=0, rdata=0, last-served=1, timeout counter=0.
REQ-016 Reset mid-transaction SHALL abandon it without issuing m_ready; the first request after release SHALL be handled as if from power-up.

Configuration
REQ-017 Macro CPU_ARB_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entry to WAIT and count each WAIT cycle; after TIMEOUT cycles without s_ready, FSM SHALL load rdata=32'hBADADD00, pulse tout_err in DONE and complete normally.
REQ-018 Macro undefined: no counter SHALL be synthesised, WAIT SHALL wait indefinitely, tout_err SHALL be constant 0.

Verification
REQ-019 m0 write addr 0x0010, wdata 0xCAFEF00D, wstrb 1111; then m0 read 0x0010 -> s_valid pulses once each; m0_ready one cycle after s_ready; m0_rdata=0xCAFEF00D; m1_ready stays 0.
REQ-020 m0 and m1 both raise valid in the same cycle after reset -> m0 served first, then m1; repeated simultaneous requests alternate m1, m0.
REQ-021 m1 halfword write 0x0004, wstrb 0011, wdata 0x0000BEEF, while m0 toggles addr during WAIT -> s_addr=0x0004 and s_wstrb=0011 throughout.
REQ-022 resetn low in WAIT, s_ready high in the same cycle -> no m_ready, all outputs at reset values; after release, m1 read 0x0008 completes normally.
REQ-023 With CPU_ARB_TIMEOUT_EN, TIMEOUT=64, s_ready held 0 -> m0_ready and tout_err pulse 66 cycles after s_valid, m0_rdata=0xBADADD00; without the macro, no completion after 1000 ns.

Source files
------------

// File: rtl/cpu_ram_arb.sv
// cpu_ram_arb: round-robin arbiter that shares one cpu_ram port between two CPU masters.
// Optional WAIT timeout is built only when CPU_ARB_TIMEOUT_EN is defined.
module cpu_ram_arb #(
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic [31:0]       m0_rdata,
  output logic              m0_ready,

  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic [31:0]       m1_rdata,
  output logic              m1_ready,

  output logic              s_valid,
  output logic [ADDR_W-1:0] s_addr,
  output logic [31:0]       s_wdata,
  output logic [3:0]        s_wstrb,
  input  logic [31:0]       s_rdata,
  input  logic              s_ready,

  output logic              tout_err
);

  // The timeout counter is 8 bits wide, so the limit must fit in it.
  if (TIMEOUT == 0 || TIMEOUT > 255) begin : g_timeout_range
    $error("cpu_ram_arb: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              pick;

`ifdef CPU_ARB_TIMEOUT_EN
  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  logic [7:0] cnt_q, cnt_d;
  logic       tout_q, tout_d;
`endif

  // Lone requester wins; on a tie the master not served last wins.
  always_comb begin
    if (m0_valid && m1_valid) begin
      pick = ~last_q;
    end else begin
      pick = m1_valid;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
`ifdef CPU_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tout_d  = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (m0_valid || m1_valid) begin
          grant_d = pick;
          addr_d  = pick ? m1_addr  : m0_addr;
          wdata_d = pick ? m1_wdata : m0_wdata;
          wstrb_d = pick ? m1_wstrb : m0_wstrb;
          state_d = StIssue;
        end
      end
      StIssue: begin
`ifdef CPU_ARB_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
        state_d = StWait;
      end
      StWait: begin
        if (s_ready) begin
          rdata_d = s_rdata;
          state_d = StDone;
        end
`ifdef CPU_ARB_TIMEOUT_EN
        else if (cnt_q == TimeoutCnt) begin
          rdata_d = 32'hBADADD00;
          tout_d  = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      StDone: begin
        last_d  = grant_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef CPU_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      tout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tout_q <= tout_d;
    end
  end

  // tout_q is only ever set on the WAIT->DONE edge, so it is high exactly in DONE.
  assign tout_err = tout_q;
`else
  assign tout_err = 1'b0;
`endif

  assign s_valid  = (state_q == StIssue);
  assign s_addr   = addr_q;
  assign s_wdata  = wdata_q;
  assign s_wstrb  = wstrb_q;
  assign m0_ready = (state_q == StDone) && !grant_q;
  assign m1_ready = (state_q == StDone) && grant_q;
  assign m0_rdata = rdata_q;
  assign m1_rdata = rdata_q;

endmodule

// File: tb/tb_cpu_ram_arb.sv
// Bench for cpu_ram_arb: grant-order table, directed corner sequences and random rounds
// checked against a transaction-level model with a behavioural RAM slave.
module tb_cpu_ram_arb;

  localparam int unsigned AW = 15;

  logic          clk, resetn;
  logic          m0_valid, m0_ready, m1_valid, m1_ready;
  logic [AW-1:0] m0_addr, m1_addr, s_addr;
  logic [31:0]   m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
  logic [3:0]    m0_wstrb, m1_wstrb, s_wstrb;
  logic          s_valid, s_ready, tout_err;

  cpu_ram_arb #(.ADDR_W(AW), .TIMEOUT(64)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .m0_valid(m0_valid),
    .m0_addr (m0_addr),
    .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb),
    .m0_rdata(m0_rdata),
    .m0_ready(m0_ready),
    .m1_valid(m1_valid),
    .m1_addr (m1_addr),
    .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb),
    .m1_rdata(m1_rdata),
    .m1_ready(m1_ready),
    .s_valid (s_valid),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_wstrb (s_wstrb),
    .s_rdata (s_rdata),
    .s_ready (s_ready),
    .tout_err(tout_err)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
  } req_t;

  typedef struct {
    bit         v0;
    bit         v1;
    logic [3:0] s0;
    logic [3:0] s1;
    int         first;
  } vec_t;

  int          total, bad;
  logic [31:0] slave_mem[16];
  logic [31:0] ref_mem[16];
  req_t        obs[$];
  int          sv_cnt;
  bit          slave_en;
  int          model_last;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    total++;
    bad++;
    $display("FAIL %s: expected event did not occur", name);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.addr  = AW'({$urandom_range(0, 15), 2'b00});
    r.wdata = $urandom;
    r.wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    return r;
  endfunction

  // Behavioural RAM: answers each request after 0..3 extra WAIT cycles.
  initial begin
    s_ready = 1'b0;
    s_rdata = '0;
    forever begin
      @(negedge clk);
      if (s_valid && slave_en) begin
        req_t o;
        o = '{addr: s_addr, wdata: s_wdata, wstrb: s_wstrb};
        obs.push_back(o);
        repeat ($urandom_range(0, 3) + 1) @(negedge clk);
        s_ready = 1'b1;
        s_rdata = slave_mem[s_addr[5:2]];
        slave_mem[s_addr[5:2]] = merge(slave_mem[s_addr[5:2]], s_wdata, s_wstrb);
        @(negedge clk);
        s_ready = 1'b0;
        s_rdata = $urandom;
      end
    end
  end

  initial begin
    sv_cnt = 0;
    forever begin
      @(negedge clk);
      if (s_valid) sv_cnt++;
    end
  end

  // One arbitration round: raise the requested valids, collect completions in expected order.
  task automatic run_round(input bit v0, input bit v1, input req_t p0, input req_t p1,
                           input int first);
    int   order[$];
    int   got, cyc, sv0;
    req_t e, o;
    if (v0 && v1) begin
      order.push_back(first);
      order.push_back(1 - first);
    end else begin
      order.push_back(v0 ? 0 : 1);
    end
    obs.delete();
    sv0 = sv_cnt;
    got = 0;
    cyc = 0;
    @(posedge clk);
    #1;
    m0_valid = v0; m0_addr = p0.addr; m0_wdata = p0.wdata; m0_wstrb = p0.wstrb;
    m1_valid = v1; m1_addr = p1.addr; m1_wdata = p1.wdata; m1_wstrb = p1.wstrb;
    while (got < order.size() && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (m0_ready || m1_ready) begin
        e = (order[got] == 0) ? p0 : p1;
        chk("ready_one_hot", {31'd0, m0_ready && m1_ready}, 32'd0);
        chk("grant_order", {31'd0, m1_ready}, 32'(order[got]));
        if (obs.size() == 0) begin
          miss("issue_before_ready");
        end else begin
          o = obs.pop_front();
          chk("s_addr", 32'(o.addr), 32'(e.addr));
          chk("s_wdata", o.wdata, e.wdata);
          chk("s_wstrb", 32'(o.wstrb), 32'(e.wstrb));
        end
        if (e.wstrb == 4'h0) begin
          chk("m0_rdata", m0_rdata, ref_mem[e.addr[5:2]]);
          chk("m1_rdata", m1_rdata, ref_mem[e.addr[5:2]]);
        end else begin
          ref_mem[e.addr[5:2]] = merge(ref_mem[e.addr[5:2]], e.wdata, e.wstrb);
        end
        if (m0_ready) m0_valid = 1'b0;
        else m1_valid = 1'b0;
        got++;
      end
    end
    if (got < order.size()) miss("round_complete");
    @(negedge clk);
    chk("s_valid_pulses", 32'(sv_cnt - sv0), 32'(order.size()));
    model_last = order[order.size() - 1];
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    model_last = 1;
  endtask

  initial begin
    vec_t vecs[7];
    req_t p0, p1, nul;
    int   cyc, hits, first;
    bit   v0, v1;

    vecs[0] = '{v0: 1, v1: 1, s0: 4'hF, s1: 4'h0, first: 0};
    vecs[1] = '{v0: 0, v1: 1, s0: 4'h0, s1: 4'h3, first: 1};
    vecs[2] = '{v0: 1, v1: 1, s0: 4'h0, s1: 4'h0, first: 0};
    vecs[3] = '{v0: 1, v1: 0, s0: 4'h1, s1: 4'h0, first: 0};
    vecs[4] = '{v0: 1, v1: 1, s0: 4'h0, s1: 4'hC, first: 1};
    vecs[5] = '{v0: 1, v1: 0, s0: 4'h0, s1: 4'h0, first: 0};
    vecs[6] = '{v0: 0, v1: 1, s0: 4'h0, s1: 4'h0, first: 1};

    total = 0; bad = 0; nul = '0; slave_en = 1'b1; model_last = 1;
    for (int i = 0; i < 16; i++) begin
      slave_mem[i] = '0;
      ref_mem[i]   = '0;
    end
    m0_valid = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    resetn = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_s_valid", {31'd0, s_valid}, 32'd0);
    chk("rst_m0_ready", {31'd0, m0_ready}, 32'd0);
    chk("rst_m1_ready", {31'd0, m1_ready}, 32'd0);
    chk("rst_tout_err", {31'd0, tout_err}, 32'd0);
    chk("rst_s_addr", 32'(s_addr), 32'd0);
    chk("rst_s_wdata", s_wdata, 32'd0);
    chk("rst_s_wstrb", 32'(s_wstrb), 32'd0);
    chk("rst_rdata", m0_rdata, 32'd0);
    resetn = 1'b1;

    // Grant-order table, starting from power-up state.
    foreach (vecs[i]) begin
      p0 = rand_req(); p0.wstrb = vecs[i].s0;
      p1 = rand_req(); p1.wstrb = vecs[i].s1;
      run_round(vecs[i].v0, vecs[i].v1, p0, p1, vecs[i].first);
    end

    // m0 write then read-back at 0x10.
    run_round(1, 0, '{addr: AW'('h10), wdata: 32'hCAFEF00D, wstrb: 4'hF}, nul, 0);
    run_round(1, 0, '{addr: AW'('h10), wdata: 32'h0, wstrb: 4'h0}, nul, 0);
    chk("readback", m0_rdata, 32'hCAFEF00D);

    // m1 halfword write while idle m0 inputs churn.
    obs.delete();
    @(posedge clk);
    #1;
    m1_valid = 1; m1_addr = AW'('h4); m1_wdata = 32'h0000BEEF; m1_wstrb = 4'b0011;
    @(negedge clk);
    cyc = 0;
    while (!m1_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
      chk("hold_s_addr", 32'(s_addr), 32'h4);
      chk("hold_s_wstrb", 32'(s_wstrb), 32'h3);
      m0_addr  = AW'($urandom);
      m0_wstrb = 4'($urandom);
      m0_wdata = $urandom;
    end
    chk("hold_done", {31'd0, m1_ready}, 32'd1);
    m1_valid = 1'b0;
    ref_mem[1] = merge(ref_mem[1], 32'h0000BEEF, 4'b0011);
    model_last = 1;
    @(negedge clk);

    // Reset in WAIT with s_ready high in the same cycle.
    slave_en = 1'b0;
    @(posedge clk);
    #1;
    m0_valid = 1; m0_addr = AW'('hC); m0_wstrb = 4'h0;
    cyc = 0;
    while (!s_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!s_valid) miss("rst_test_issue");
    @(negedge clk);
    s_ready = 1'b1;
    s_rdata = 32'h12345678;
    resetn  = 1'b0;
    #1;
    chk("midrst_m0_ready", {31'd0, m0_ready}, 32'd0);
    chk("midrst_m1_ready", {31'd0, m1_ready}, 32'd0);
    chk("midrst_s_valid", {31'd0, s_valid}, 32'd0);
    chk("midrst_s_addr", 32'(s_addr), 32'd0);
    chk("midrst_s_wdata", s_wdata, 32'd0);
    chk("midrst_rdata", m1_rdata, 32'd0);
    @(negedge clk);
    chk("midrst_no_ready", {31'd0, m0_ready | m1_ready}, 32'd0);
    s_ready = 1'b0;
    m0_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    model_last = 1;
    slave_en = 1'b1;
    run_round(0, 1, nul, '{addr: AW'('h8), wdata: 32'h0, wstrb: 4'h0}, 1);

    // Random rounds against the transaction model.
    for (int n = 0; n < 40; n++) begin
      do begin
        v0 = 1'($urandom);
        v1 = 1'($urandom);
      end while (!v0 && !v1);
      first = (v0 && v1) ? ((model_last == 1) ? 0 : 1) : (v0 ? 0 : 1);
      run_round(v0, v1, rand_req(), rand_req(), first);
    end

    // Slave never answers.
    slave_en = 1'b0;
    @(posedge clk);
    #1;
    m0_valid = 1; m0_addr = AW'('h14); m0_wstrb = 4'h0;
    cyc = 0;
    while (!s_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!s_valid) miss("tout_test_issue");
`ifdef CPU_ARB_TIMEOUT_EN
    cyc = 0;
    while (!m0_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("tout_latency", 32'(cyc), 32'd66);
    chk("tout_err", {31'd0, tout_err}, 32'd1);
    chk("tout_rdata", m0_rdata, 32'hBADADD00);
    m0_valid = 1'b0;
    @(negedge clk);
    chk("tout_err_pulse", {31'd0, tout_err}, 32'd0);
`else
    hits = 0;
    repeat (100) begin
      @(negedge clk);
      if (m0_ready || m1_ready || tout_err) hits++;
    end
    chk("no_completion", 32'(hits), 32'd0);
    m0_valid = 1'b0;
`endif
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
